// File: rtl/rgb_led_pkg.sv
// Shared state codes and colour-stepping helper for the RGB LED sequencer.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RED   = 2'd1,
        ST_GREEN = 2'd2,
        ST_BLUE  = 2'd3
    } state_t;

    // Colour rotation RED -> GREEN -> BLUE -> RED; IDLE starts at RED.
    function automatic state_t next_colour(input state_t s);
        state_t n;
        case (s)
            ST_RED:   n = ST_GREEN;
            ST_GREEN: n = ST_BLUE;
            ST_BLUE:  n = ST_RED;
            default:  n = ST_RED;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rgb_led_sequencer_if.sv
// Board-facing signal bundle: raw buttons in, LED pins and debug state out.
interface rgb_led_if;
    logic       push_button0;
    logic       push_button1;
    logic       led_red;
    logic       led_green;
    logic       led_blue;
    logic [1:0] state_dbg;

    modport master (
        output push_button0, push_button1,
        input  led_red, led_green, led_blue, state_dbg
    );

    modport slave (
        input  push_button0, push_button1,
        output led_red, led_green, led_blue, state_dbg
    );
endinterface

// File: rtl/rgb_led_sequencer_button_debouncer.sv
// Per-button synchronizer, stability counter and press-pulse generator.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic level,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button_in;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges; pulse on rising accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rgb_led_sequencer.sv
// RGB LED sequencer: colour FSM with dwell auto-advance and a shared PWM brightness stage.
// state   | meaning
// IDLE    | all LEDs off, waiting for start press
// RED     | red LED driven by PWM
// GREEN   | green LED driven by PWM
// BLUE    | blue LED driven by PWM
module rgb_led_sequencer
    import rgb_led_pkg::*;
#(
    parameter int                  DEBOUNCE_CYCLES = 250000,
    parameter int                  DWELL_CYCLES    = 12000000,
    parameter int                  PWM_BITS        = 8,
    parameter logic [PWM_BITS-1:0] DUTY            = 64
) (
    input logic     clock,
    input logic     reset,
    rgb_led_if.slave io
);
    localparam int DWELL_W = $clog2(DWELL_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [DWELL_W-1:0]  dwell_cnt;
    logic [DWELL_W-1:0]  dwell_next;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic                press0;
    logic                press1;
    logic                level0;
    logic                level1;
    logic                red_next;
    logic                green_next;
    logic                blue_next;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
        .clock     (clock),
        .reset     (reset),
        .button_in (io.push_button0),
        .level     (level0),
        .press     (press0)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clock     (clock),
        .reset     (reset),
        .button_in (io.push_button1),
        .level     (level1),
        .press     (press1)
    );

    // State and dwell counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            dwell_cnt <= '0;
        end else begin
            state     <= state_next;
            dwell_cnt <= dwell_next;
        end
    end

    // Next state: stop wins, then start/step; a press on the expiry cycle still steps only once.
    always_comb begin
        state_next = state;
        dwell_next = dwell_cnt;
        if (press1) begin
            state_next = ST_IDLE;
            dwell_next = '0;
        end else if (state == ST_IDLE) begin
            dwell_next = '0;
            if (press0) state_next = ST_RED;
        end else if (press0 || (dwell_cnt == DWELL_LAST)) begin
            state_next = next_colour(state);
            dwell_next = '0;
        end else begin
            dwell_next = dwell_cnt + 1'b1;
        end
    end

    // Free-running PWM counter, independent of the colour state.
    always_ff @(posedge clock) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign pwm_on = (pwm_cnt < DUTY);

    // Per-colour LED enables decoded from the current state.
    always_comb begin
        red_next   = (state == ST_RED)   && pwm_on;
        green_next = (state == ST_GREEN) && pwm_on;
        blue_next  = (state == ST_BLUE)  && pwm_on;
    end

    // Registered pin drivers and debug state.
    always_ff @(posedge clock) begin
        if (reset) begin
            io.led_red   <= 1'b0;
            io.led_green <= 1'b0;
            io.led_blue  <= 1'b0;
            io.state_dbg <= ST_IDLE;
        end else begin
            io.led_red   <= red_next;
            io.led_green <= green_next;
            io.led_blue  <= blue_next;
            io.state_dbg <= state;
        end
    end

    logic unused_levels;
    assign unused_levels = level0 ^ level1;
endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Randomized bench for rgb_led_sequencer with a behavioural model and a few literal timing pins.
module tb_rgb_led_sequencer;
    localparam int DEB   = 4;
    localparam int DWELL = 20;
    localparam int PB    = 3;
    localparam int DUTY  = 4;
    localparam int HL    = DEB + 1;

    logic clock;
    logic reset;
    rgb_led_if bus();

    rgb_led_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .DWELL_CYCLES    (DWELL),
        .PWM_BITS        (PB),
        .DUTY            (3'd4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model: raw-sample history windows, integer colour and counters.
    int h0[HL];
    int h1[HL];
    int m_state, m_dwell, m_pwm, m_lvl0, m_lvl1, m_pr0, m_pr1;
    int e_dbg;
    int e_led[3];
    bit m_valid = 1'b0;

    always @(posedge clock) begin
        int raw0, raw1;
        bit diff0, diff1;
        raw0 = int'(bus.push_button0);
        raw1 = int'(bus.push_button1);
        if (reset) begin
            for (int i = 0; i < HL; i++) begin h0[i] = 0; h1[i] = 0; end
            m_state = 0; m_dwell = 0; m_pwm = 0;
            m_lvl0 = 0; m_lvl1 = 0; m_pr0 = 0; m_pr1 = 0;
            e_dbg = 0;
            for (int k = 0; k < 3; k++) e_led[k] = 0;
            m_valid = 1'b1;
        end else begin
            e_dbg = m_state;
            for (int k = 0; k < 3; k++) e_led[k] = (m_state == k + 1 && m_pwm < DUTY) ? 1 : 0;
            if (m_pr1 != 0) begin
                m_state = 0; m_dwell = 0;
            end else if (m_state == 0) begin
                if (m_pr0 != 0) m_state = 1;
                m_dwell = 0;
            end else if (m_pr0 != 0 || m_dwell == DWELL - 1) begin
                m_state = (m_state == 3) ? 1 : m_state + 1;
                m_dwell = 0;
            end else begin
                m_dwell++;
            end
            m_pwm = (m_pwm + 1) % (1 << PB);
            diff0 = 1'b1; diff1 = 1'b1;
            for (int i = 1; i <= DEB; i++) begin
                if (h0[i] == m_lvl0) diff0 = 1'b0;
                if (h1[i] == m_lvl1) diff1 = 1'b0;
            end
            if (diff0) begin m_lvl0 = 1 - m_lvl0; m_pr0 = m_lvl0; end else m_pr0 = 0;
            if (diff1) begin m_lvl1 = 1 - m_lvl1; m_pr1 = m_lvl1; end else m_pr1 = 0;
            for (int i = HL - 1; i > 0; i--) begin h0[i] = h0[i-1]; h1[i] = h1[i-1]; end
            h0[0] = raw0; h1[0] = raw1;
        end
        #1;
        if (m_valid) begin
            vectors++;
            if (int'(bus.state_dbg) != e_dbg || int'(bus.led_red) != e_led[0] ||
                int'(bus.led_green) != e_led[1] || int'(bus.led_blue) != e_led[2]) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t dbg/r/g/b actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                         $time, bus.state_dbg, bus.led_red, bus.led_green, bus.led_blue,
                         e_dbg, e_led[0], e_led[1], e_led[2]);
            end
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_dbg(input int v, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (int'(bus.state_dbg) != v && n < limit);
    endtask

    task automatic run_len(input int v, output int n);
        n = 1;
        while (n < 100) begin
            @(negedge clock);
            if (int'(bus.state_dbg) != v) break;
            n++;
        end
    endtask

    function automatic int leds();
        return int'({bus.led_red, bus.led_green, bus.led_blue});
    endfunction

    initial begin
        int n;
        int d0, d1;
        reset = 1'b1;
        bus.push_button0 = 1'b0;
        bus.push_button1 = 1'b0;

        // reset with buttons toggling
        @(negedge clock);
        check_lit("reset_edge_dbg", int'(bus.state_dbg), 0);
        check_lit("reset_edge_leds", leds(), 0);
        repeat (2) begin
            bus.push_button0 = 1'($urandom_range(0, 1));
            bus.push_button1 = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        reset = 1'b0;
        bus.push_button0 = 1'b0;
        bus.push_button1 = 1'b0;
        repeat (8) @(negedge clock);
        check_lit("after_reset_dbg", int'(bus.state_dbg), 0);

        // short bounce is ignored
        bus.push_button0 = 1'b1;
        repeat (3) @(negedge clock);
        bus.push_button0 = 1'b0;
        repeat (10) @(negedge clock);
        check_lit("bounce_dbg", int'(bus.state_dbg), 0);

        // clean press: debug state shows RED 8 edges after the first sampling edge
        bus.push_button0 = 1'b1;
        wait_dbg(1, 40, n);
        check_lit("press_latency", n, 8);
        bus.push_button0 = 1'b0;

        // dwell auto-advance through all colours and wrap
        run_len(1, n); check_lit("red_dwell", n, 20);
        run_len(2, n); check_lit("green_dwell", n, 20);
        run_len(3, n); check_lit("blue_dwell", n, 20);
        check_lit("wrap_to_red", int'(bus.state_dbg), 1);

        // simultaneous start and stop in GREEN returns to IDLE
        wait_dbg(2, 40, n);
        bus.push_button0 = 1'b1;
        bus.push_button1 = 1'b1;
        wait_dbg(0, 40, n);
        check_lit("both_press_idle", n, 8);
        bus.push_button0 = 1'b0;
        bus.push_button1 = 1'b0;
        repeat (10) @(negedge clock);

        // press landing on the dwell-expiry edge steps exactly one colour
        bus.push_button0 = 1'b1;
        wait_dbg(1, 40, n);
        check_lit("restart_latency", n, 8);
        bus.push_button0 = 1'b0;
        repeat (12) @(negedge clock);
        bus.push_button0 = 1'b1;
        run_len(1, n); check_lit("red_tail", n, 8);
        check_lit("expiry_press_green", int'(bus.state_dbg), 2);
        run_len(2, n); check_lit("green_after_expiry", n, 20);
        bus.push_button0 = 1'b0;

        // reset in BLUE with start held, then re-press after release
        wait_dbg(3, 60, n);
        check_lit("reach_blue", int'(bus.state_dbg), 3);
        bus.push_button0 = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        check_lit("blue_reset_dbg", int'(bus.state_dbg), 0);
        check_lit("blue_reset_leds", leds(), 0);
        reset = 1'b0;
        wait_dbg(1, 40, n);
        check_lit("held_through_reset", n, 8);
        bus.push_button0 = 1'b0;

        // randomized phase checked by the model
        d0 = 0; d1 = 0;
        repeat (3000) begin
            if (d0 == 0) begin
                bus.push_button0 = 1'($urandom_range(0, 1));
                d0 = int'($urandom_range(1, 12));
            end
            if (d1 == 0) begin
                bus.push_button1 = ($urandom_range(0, 5) == 0);
                d1 = int'($urandom_range(1, 12));
            end
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clock);
            d0--; d1--;
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
